uart_ctrl: RTL and testbench

Memory-mapped controller sitting between the Ibex data bus and the async_transmitter/async_receiver pair. It buffers outgoing bytes in a TX FIFO and sequences the transmitter's start/busy handshake one byte at a time. It captures received bytes into an RX FIFO and exposes DATA/STATUS registers to software. It is the single point through which firmware drives the SoC's RS-232 line.

---
 rtl/uart_ctrl_pkg.sv | 24 ++
 rtl/uart_ctrl_if.sv | 16 +
 rtl/uart_fifo.sv | 49 ++++
 rtl/uart_ctrl.sv | 128 ++++++++++++
 tb/tb_uart_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared constants and types for the UART controller: register map, STATUS bit layout, TX FSM states.
package uart_ctrl_pkg;

   localparam int unsigned AddrW = 3;
   localparam int unsigned DataW = 32;
   localparam int unsigned ByteW = 8;

   localparam logic [AddrW-1:0] DATA_OFFS   = 3'h0;
   localparam logic [AddrW-1:0] STATUS_OFFS = 3'h4;

   localparam int unsigned StTxFull     = 0;
   localparam int unsigned StTxEmpty    = 1;
   localparam int unsigned StRxNonempty = 2;
   localparam int unsigned StRxOverrun  = 3;
   localparam int unsigned StTxActive   = 4;
   localparam int unsigned StIenTx      = 8;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_BUSY,
      WAIT_DONE
   } tx_state_e;

endpackage

// File: rtl/uart_ctrl_if.sv
// Ibex-style data bus between the core (master) and the UART controller (slave).
interface uart_ctrl_if;
   import uart_ctrl_pkg::*;

   logic             req_i;
   logic             we_i;
   logic [AddrW-1:0] addr_i;
   logic [DataW-1:0] wdata_i;
   logic             gnt_o;
   logic             rvalid_o;
   logic [DataW-1:0] rdata_o;

   modport slave  (input  req_i, we_i, addr_i, wdata_i, output gnt_o, rvalid_o, rdata_o);
   modport master (output req_i, we_i, addr_i, wdata_i, input  gnt_o, rvalid_o, rdata_o);

endinterface

// File: rtl/uart_fifo.sv
// Synchronous FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module uart_fifo #(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 8
) (
   input  logic             clk,
   input  logic             rst_ni,
   input  logic             push,
   input  logic             pop,
   input  logic [Width-1:0] wdata,
   output logic [Width-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = PtrW + 1;

   logic [Width-1:0] mem [Depth];
   logic [PtrW-1:0]  wrPtr;
   logic [PtrW-1:0]  rdPtr;
   logic [CntW-1:0]  count;
   logic             doPush;
   logic             doPop;

   assign full   = (count == CntW'(Depth));
   assign empty  = (count == '0);
   assign doPop  = pop & ~empty;
   assign doPush = push & (~full | doPop);
   assign rdata  = mem[rdPtr];

   // Pointers wrap naturally since Depth is a power of two
   always_ff @(posedge clk) begin
      if (!rst_ni) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + PtrW'(1);
         if (doPop)  rdPtr <= rdPtr + PtrW'(1);
         count <= count + CntW'(doPush) - CntW'(doPop);
      end
   end

   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr] <= wdata;
   end

endmodule

// File: rtl/uart_ctrl.sv
// Memory-mapped UART controller: TX/RX FIFOs, DATA/STATUS registers, transmitter start/busy sequencing.
// Optional interrupt output and STATUS.ien_tx enabled by defining UART_CTRL_IRQ_EN.
module uart_ctrl
   import uart_ctrl_pkg::*;
#(
   parameter int unsigned TxDepth = 8,
   parameter int unsigned RxDepth = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   uart_ctrl_if.slave       bus,
   output logic             tx_start_o,
   output logic [ByteW-1:0] tx_data_o,
   input  logic             tx_busy_i,
   input  logic             rx_ready_i,
`ifdef UART_CTRL_IRQ_EN
   output logic             irq_o,
`endif
   input  logic [ByteW-1:0] rx_data_i
);

   logic [AddrW-1:0] wordAddr;
   logic             isData, isStatus, wrReq, rdReq;
   logic             txPush, txPop, txFull, txEmpty;
   logic             rxPop, rxFull, rxEmpty;
   logic [ByteW-1:0] txHead, rxHead;
   logic             overrun, overrunSet, overrunClr, txActive, ienTx;
   logic [DataW-1:0] statusWord, readWord;
   tx_state_e        txState;

   assign wordAddr = {bus.addr_i[AddrW-1:2], 2'b00};
   assign isData   = (wordAddr == DATA_OFFS);
   assign isStatus = (wordAddr == STATUS_OFFS);
   assign wrReq    = bus.req_i & bus.we_i;
   assign rdReq    = bus.req_i & ~bus.we_i;
   assign bus.gnt_o = bus.req_i;

   assign txPush     = wrReq & isData;
   assign txPop      = (txState == IDLE) & ~txEmpty & ~tx_busy_i;
   assign rxPop      = rdReq & isData & ~rxEmpty;
   assign overrunSet = rx_ready_i & rxFull & ~rxPop;
   assign overrunClr = wrReq & isStatus & bus.wdata_i[StRxOverrun];
   assign txActive   = (txState != IDLE) | tx_busy_i;

   uart_fifo #(.Width(ByteW), .Depth(TxDepth)) txFifo (
      .clk(clk_i), .rst_ni(rst_ni), .push(txPush), .pop(txPop),
      .wdata(bus.wdata_i[ByteW-1:0]), .rdata(txHead), .full(txFull), .empty(txEmpty)
   );

   uart_fifo #(.Width(ByteW), .Depth(RxDepth)) rxFifo (
      .clk(clk_i), .rst_ni(rst_ni), .push(rx_ready_i), .pop(rxPop),
      .wdata(rx_data_i), .rdata(rxHead), .full(rxFull), .empty(rxEmpty)
   );

`ifdef UART_CTRL_IRQ_EN
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         ienTx <= 1'b0;
         irq_o <= 1'b0;
      end else begin
         if (wrReq && isStatus) ienTx <= bus.wdata_i[StIenTx];
         irq_o <= ~rxEmpty | overrun | (txEmpty & ienTx);
      end
   end

   logic unusedBits;
   assign unusedBits = ^{bus.wdata_i[DataW-1:StIenTx+1], bus.addr_i[1:0]};
`else
   assign ienTx = 1'b0;

   logic unusedBits;
   assign unusedBits = ^{bus.wdata_i[DataW-1:StIenTx], bus.addr_i[1:0]};
`endif

   always_comb begin
      statusWord               = '0;
      statusWord[StTxFull]     = txFull;
      statusWord[StTxEmpty]    = txEmpty;
      statusWord[StRxNonempty] = ~rxEmpty;
      statusWord[StRxOverrun]  = overrun;
      statusWord[StTxActive]   = txActive;
      statusWord[StIenTx]      = ienTx;
   end

   // DATA read of an empty RX FIFO returns all zeros (valid bit clear)
   always_comb begin
      readWord = '0;
      if (isStatus)     readWord = statusWord;
      else if (!rxEmpty) readWord = {23'b0, 1'b1, rxHead};
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         bus.rvalid_o <= 1'b0;
         bus.rdata_o  <= '0;
         overrun      <= 1'b0;
      end else begin
         bus.rvalid_o <= bus.req_i;
         bus.rdata_o  <= rdReq ? readWord : '0;
         if (overrunSet)      overrun <= 1'b1;
         else if (overrunClr) overrun <= 1'b0;
      end
   end

   // One start pulse per byte, then follow the transmitter's busy rise and fall
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         txState    <= IDLE;
         tx_start_o <= 1'b0;
         tx_data_o  <= '0;
      end else begin
         tx_start_o <= 1'b0;
         case (txState)
            IDLE: begin
               if (txPop) begin
                  tx_start_o <= 1'b1;
                  tx_data_o  <= txHead;
                  txState    <= WAIT_BUSY;
               end
            end
            WAIT_BUSY: if (tx_busy_i)  txState <= WAIT_DONE;
            WAIT_DONE: if (!tx_busy_i) txState <= IDLE;
            default:   txState <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_ctrl.sv
// Self-checking bench for uart_ctrl: bus read scoreboard, TX start scoreboard, transmitter busy model.
module tb_uart_ctrl;
   import uart_ctrl_pkg::*;

`ifdef UART_CTRL_IRQ_EN
   localparam logic [31:0] IenBit = 32'h100;
`else
   localparam logic [31:0] IenBit = 32'h000;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       txStart;
   logic [7:0] txData;
   logic       txBusy;
   logic       busyForce = 1'b0;
   int         busyCnt = 0;
   logic       rxReady = 1'b0;
   logic [7:0] rxData = 8'h00;
`ifdef UART_CTRL_IRQ_EN
   logic       irq;
`endif

   int checks = 0;
   int errors = 0;
   int cycle = 0;
   int starts = 0;
   int lastStart = -100;
   logic [31:0] rdExp[$];
   logic [7:0]  txExp[$];

   uart_ctrl_if bus();

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   assign txBusy = busyForce | (busyCnt != 0);

   // Transmitter model: busy for 10 cycles starting the cycle after a start pulse
   always @(posedge clk) begin
      if (txStart)          busyCnt <= 10;
      else if (busyCnt != 0) busyCnt <= busyCnt - 1;
   end

   uart_ctrl #(.TxDepth(8), .RxDepth(8)) dut (
      .clk_i(clk), .rst_ni(rst_n), .bus(bus),
      .tx_start_o(txStart), .tx_data_o(txData), .tx_busy_i(txBusy),
      .rx_ready_i(rxReady),
`ifdef UART_CTRL_IRQ_EN
      .irq_o(irq),
`endif
      .rx_data_i(rxData)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeoutFail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timeout (t=%0t)", name, $time);
   endtask

   // Bus and TX monitors compare against the scoreboards
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.rvalid_o) begin
            if (rdExp.size() == 0) begin
               checks++; errors++;
               $display("FAIL rvalid: got unexpected response 0x%0h expected none", bus.rdata_o);
            end else chk("rdata", bus.rdata_o, rdExp.pop_front());
         end
         if (txStart) begin
            starts++;
            if (txExp.size() == 0) begin
               checks++; errors++;
               $display("FAIL tx_start: got unexpected start data 0x%0h expected none", txData);
            end else chk("tx_data", {24'b0, txData}, {24'b0, txExp.pop_front()});
            chk("tx_busy_at_start", {31'b0, txBusy}, 32'h0);
            chk("tx_gap_ok", {31'b0, (cycle - lastStart) >= 3}, 32'h1);
            lastStart = cycle;
         end
      end
   end

   task automatic busOp(input logic we, input logic [2:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp, input logic rxP = 1'b0, input logic [7:0] rxB = 8'h00);
      @(negedge clk);
      bus.req_i = 1'b1; bus.we_i = we; bus.addr_i = addr; bus.wdata_i = wdata;
      rxReady = rxP; rxData = rxB;
      rdExp.push_back(exp);
      #1 chk("gnt", {31'b0, bus.gnt_o}, 32'h1);
      @(negedge clk);
      bus.req_i = 1'b0; bus.we_i = 1'b0; rxReady = 1'b0;
   endtask

   task automatic rxPulse(input logic [7:0] b);
      @(negedge clk);
      rxReady = 1'b1; rxData = b;
      @(negedge clk);
      rxReady = 1'b0;
   endtask

   task automatic waitTxIdle(input int budget);
      int i;
      for (i = 0; i < budget; i++) begin
         @(negedge clk);
         if (txExp.size() == 0 && !txBusy && (cycle - lastStart) > 3) break;
      end
      if (i == budget) timeoutFail("tx_drain");
      repeat (3) @(negedge clk);
   endtask

   typedef struct {
      logic        pulse;
      logic [7:0]  rxB;
      logic        we;
      logic [2:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[9];

   initial begin
      int s0;
      int i;
      vecs[0] = '{1'b1, 8'h5A, 1'b0, 3'h0, 32'h0,   32'h15A};
      vecs[1] = '{1'b0, 8'h00, 1'b0, 3'h2, 32'h0,   32'h000};
      vecs[2] = '{1'b0, 8'h00, 1'b0, 3'h4, 32'h0,   32'h002};
      vecs[3] = '{1'b1, 8'hA5, 1'b0, 3'h5, 32'h0,   32'h006};
      vecs[4] = '{1'b0, 8'h00, 1'b0, 3'h0, 32'h0,   32'h1A5};
      vecs[5] = '{1'b0, 8'h00, 1'b1, 3'h4, 32'h100, 32'h000};
      vecs[6] = '{1'b0, 8'h00, 1'b0, 3'h4, 32'h0,   32'h002 | IenBit};
      vecs[7] = '{1'b0, 8'h00, 1'b1, 3'h4, 32'h0,   32'h000};
      vecs[8] = '{1'b0, 8'h00, 1'b0, 3'h4, 32'h0,   32'h002};

      bus.req_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.wdata_i = '0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_rvalid", {31'b0, bus.rvalid_o}, 32'h0);
      chk("rst_rdata", bus.rdata_o, 32'h0);
      chk("rst_tx_start", {31'b0, txStart}, 32'h0);
      chk("rst_tx_data", {24'b0, txData}, 32'h0);
      chk("rst_gnt", {31'b0, bus.gnt_o}, 32'h0);
      rst_n = 1'b1;
      busOp(1'b0, STATUS_OFFS, 32'h0, 32'h002);

      // Two bytes through the transmitter model
      txExp.push_back(8'h41); txExp.push_back(8'h42);
      busOp(1'b1, DATA_OFFS, 32'h41, 32'h0);
      busOp(1'b1, DATA_OFFS, 32'hFFFF_FF42, 32'h0);
      waitTxIdle(300);
      chk("tx_data_hold", {24'b0, txData}, 32'h42);
      busOp(1'b0, STATUS_OFFS, 32'h0, 32'h002);

      // TX FIFO overflow while transmitter is busy
      busyForce = 1'b1;
      for (int k = 0; k < 9; k++) begin
         if (k < 8) txExp.push_back(8'(8'h10 + k));
         busOp(1'b1, DATA_OFFS, 32'(8'h10 + k), 32'h0);
      end
      busOp(1'b0, STATUS_OFFS, 32'h0, 32'h011);
      s0 = starts;
      busyForce = 1'b0;
      waitTxIdle(800);
      chk("tx_starts_8", 32'(starts - s0), 32'd8);
      busOp(1'b0, STATUS_OFFS, 32'h0, 32'h002);

      // Table-driven register vectors
      for (int k = 0; k < 9; k++) begin
         if (vecs[k].pulse) rxPulse(vecs[k].rxB);
         busOp(vecs[k].we, vecs[k].addr, vecs[k].wdata, vecs[k].exp);
      end

      // RX overrun, in-order readback, clear
      for (int k = 0; k < 9; k++) rxPulse(8'(8'h30 + k));
      busOp(1'b0, STATUS_OFFS, 32'h0, 32'h00E);
      for (int k = 0; k < 8; k++) busOp(1'b0, DATA_OFFS, 32'h0, 32'h130 + 32'(k));
      busOp(1'b0, STATUS_OFFS, 32'h0, 32'h00A);
      busOp(1'b1, STATUS_OFFS, 32'h8, 32'h0);
      busOp(1'b0, STATUS_OFFS, 32'h0, 32'h002);

      // Full RX FIFO: push in the same cycle as a DATA read is accepted
      for (int k = 0; k < 8; k++) rxPulse(8'(8'h60 + k));
      busOp(1'b0, STATUS_OFFS, 32'h0, 32'h006);
      busOp(1'b0, DATA_OFFS, 32'h0, 32'h160, 1'b1, 8'h77);
      busOp(1'b0, STATUS_OFFS, 32'h0, 32'h006);
      for (int k = 1; k < 8; k++) busOp(1'b0, DATA_OFFS, 32'h0, 32'h160 + 32'(k));
      busOp(1'b0, DATA_OFFS, 32'h0, 32'h177);
      busOp(1'b0, DATA_OFFS, 32'h0, 32'h000);

      // Overrun set wins over a same-cycle clear
      for (int k = 0; k < 8; k++) rxPulse(8'(8'h80 + k));
      busOp(1'b1, STATUS_OFFS, 32'h8, 32'h0, 1'b1, 8'h99);
      busOp(1'b0, STATUS_OFFS, 32'h0, 32'h00E);

      // Reset during WAIT_DONE with three bytes still queued
      s0 = starts;
      txExp.push_back(8'hC0);
      for (int k = 0; k < 4; k++) busOp(1'b1, DATA_OFFS, 32'(8'hC0 + k), 32'h0);
      for (i = 0; i < 100 && starts == s0; i++) @(negedge clk);
      if (starts == s0) timeoutFail("rst_test_start");
      for (i = 0; i < 100 && !txBusy; i++) @(negedge clk);
      if (!txBusy) timeoutFail("rst_test_busy");
      busyForce = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_mid_tx_start", {31'b0, txStart}, 32'h0);
      chk("rst_mid_rvalid", {31'b0, bus.rvalid_o}, 32'h0);
      rst_n = 1'b1;
      busOp(1'b0, STATUS_OFFS, 32'h0, 32'h012);
      busyForce = 1'b0;
      repeat (50) @(negedge clk);
      chk("rst_no_more_starts", 32'(starts - s0), 32'd1);
      busOp(1'b0, STATUS_OFFS, 32'h0, 32'h002);

      for (i = 0; i < 20 && rdExp.size() != 0; i++) @(negedge clk);
      if (rdExp.size() != 0) timeoutFail("rdata_drain");
      chk("tx_queue_empty", 32'(txExp.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not complete (checks %0d, errors %0d)", checks, errors);
      $fatal(1);
   end

endmodule
